// File: rtl/pc_pkg.sv
// Shared types and encodings for the IF-stage program-counter generator.
package pc_pkg;

    // 2-bit saturating branch counter encodings
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Fetch FSM states
    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // BTB entry fields are sized for the widest supported XLEN (64);
    // narrower configurations zero-extend on write and slice on read.
    localparam int unsigned BTB_FIELD_MAX = 64;
    typedef logic [BTB_FIELD_MAX-1:0] btb_field_t;

    typedef struct packed {
        logic       valid;
        btb_field_t tag;
        btb_field_t target;
        logic [1:0] ctr;
    } btb_entry_t;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the current
// fetch pc, trained from EX with 2-bit saturating counters.
module pc_btb
    import pc_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken,
    output logic [XLEN-1:0] lookup_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken
);

    localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = XLEN - IDX - 2;

    btb_entry_t entries [BTB_ENTRIES];

    logic [IDX-1:0]  rd_idx;
    logic [TAGW-1:0] rd_tag;
    btb_entry_t      rd_e;
    logic [IDX-1:0]  wr_idx;
    logic [TAGW-1:0] wr_tag;
    btb_entry_t      wr_e;
    logic            wr_hit;
    logic            unused_bits;

    assign rd_idx = lookup_pc[IDX+1:2];
    assign rd_tag = lookup_pc[XLEN-1:IDX+2];
    assign wr_idx = upd_pc[IDX+1:2];
    assign wr_tag = upd_pc[XLEN-1:IDX+2];

    // Byte-offset bits never take part in indexing or tagging
    assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Lookup reads the stored state, so a same-cycle update is not seen yet
    always_comb begin
        rd_e          = entries[rd_idx];
        lookup_taken  = rd_e.valid && (rd_e.tag[TAGW-1:0] == rd_tag) && rd_e.ctr[1];
        lookup_target = rd_e.target[XLEN-1:0];
    end

    // Hit detection for the training port
    always_comb begin
        wr_e   = entries[wr_idx];
        wr_hit = wr_e.valid && (wr_e.tag[TAGW-1:0] == wr_tag);
    end

    // Training and allocation; reset only clears the valid bits
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else if (upd_valid) begin
            if (wr_hit) begin
                if (upd_taken) begin
                    entries[wr_idx].ctr    <= ctr_inc(wr_e.ctr);
                    entries[wr_idx].target <= btb_field_t'(upd_target);
                end else begin
                    entries[wr_idx].ctr    <= ctr_dec(wr_e.ctr);
                end
            end else if (upd_taken) begin
                entries[wr_idx].valid  <= 1'b1;
                entries[wr_idx].tag    <= btb_field_t'(wr_tag);
                entries[wr_idx].target <= btb_field_t'(upd_target);
                entries[wr_idx].ctr    <= CTR_WT;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// IF-stage program-counter generator: boot FSM, next-pc priority mux and
// the pc register, with a small BTB for taken-branch prediction.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     BTB_ENTRIES  = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);

    state_t          state;
    logic [XLEN-1:0] next_pc;
    logic            btb_taken;
    logic [XLEN-1:0] btb_target;

    pc_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk           (clk),
        .reset_n       (reset_n),
        .lookup_pc     (pc),
        .lookup_taken  (btb_taken),
        .lookup_target (btb_target),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .upd_taken     (upd_taken)
    );

    // Predictions are suppressed until the first real fetch
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = '0;
        if (state == ST_RUN) begin
            pred_taken  = btb_taken;
            pred_target = btb_target;
        end
    end

    // Next-pc selection: trap, redirect, stall, prediction, sequential
    always_comb begin
        if (trap_valid) begin
            next_pc = trap_target;
        end else if (redirect_valid) begin
            next_pc = redirect_target;
        end else if (stall) begin
            next_pc = pc;
        end else if (pred_taken) begin
            next_pc = pred_target;
        end else begin
            next_pc = pc + XLEN'(4);
        end
    end

    // Boot FSM and pc register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_BOOT;
            pc       <= RESET_VECTOR;
            pc_valid <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state    <= ST_RUN;
                    pc       <= RESET_VECTOR;
                    pc_valid <= 1'b1;
                end
                ST_RUN: begin
                    pc       <= next_pc;
                    pc_valid <= 1'b1;
                end
                default: begin
                    state    <= ST_BOOT;
                    pc       <= RESET_VECTOR;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed, table-driven bench for pc_gen (XLEN=32, RESET_VECTOR=0x8000_0000,
// 8 BTB entries).
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        trap_valid;
    logic [31:0] trap_target;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pred_taken;
    logic [31:0] pred_target;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        logic        stall;
        logic        trap_valid;
        logic [31:0] trap_target;
        logic        redirect_valid;
        logic [31:0] redirect_target;
        logic        upd_valid;
        logic [31:0] upd_pc;
        logic [31:0] upd_target;
        logic        upd_taken;
        logic [31:0] exp_pc;
        logic        exp_pred;
        logic [31:0] exp_ptgt;
    } vec_t;

    vec_t vecs[$];

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h8000_0000),
        .BTB_ENTRIES  (8)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .trap_valid      (trap_valid),
        .trap_target     (trap_target),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_target      (upd_target),
        .upd_taken       (upd_taken),
        .pc              (pc),
        .pc_valid        (pc_valid),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string name, input logic st,
                                input logic tv, input logic [31:0] tt,
                                input logic rv, input logic [31:0] rt,
                                input logic uv, input logic [31:0] up,
                                input logic [31:0] ut, input logic uk,
                                input logic [31:0] epc, input logic ep,
                                input logic [31:0] ept);
        vec_t v;
        v.name = name; v.stall = st;
        v.trap_valid = tv; v.trap_target = tt;
        v.redirect_valid = rv; v.redirect_target = rt;
        v.upd_valid = uv; v.upd_pc = up; v.upd_target = ut; v.upd_taken = uk;
        v.exp_pc = epc; v.exp_pred = ep; v.exp_ptgt = ept;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 1'b0; trap_valid = 1'b0; trap_target = '0;
        redirect_valid = 1'b0; redirect_target = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input logic [31:0] epc,
                               input logic ev, input logic ep, input logic [31:0] ept,
                               input logic check_tgt);
        chk({name, ".pc"}, pc, epc);
        chk({name, ".pc_valid"}, 32'(pc_valid), 32'(ev));
        chk({name, ".pred_taken"}, 32'(pred_taken), 32'(ep));
        if (check_tgt) chk({name, ".pred_target"}, pred_target, ept);
    endtask

    initial begin
        //          name          st tv tt            rv rt            uv up            ut            uk  exp_pc        ep exp_ptgt
        vecs.push_back(mk("boot",        0,0,32'h0,        0,32'h0,        0,32'h0,        32'h0,        0, 32'h8000_0000,0,32'h0));
        vecs.push_back(mk("seq4",        0,0,32'h0,        0,32'h0,        0,32'h0,        32'h0,        0, 32'h8000_0004,0,32'h0));
        vecs.push_back(mk("seq8",        0,0,32'h0,        0,32'h0,        0,32'h0,        32'h0,        0, 32'h8000_0008,0,32'h0));
        vecs.push_back(mk("stall1",      1,0,32'h0,        0,32'h0,        0,32'h0,        32'h0,        0, 32'h8000_0008,0,32'h0));
        vecs.push_back(mk("stall2",      1,0,32'h0,        0,32'h0,        0,32'h0,        32'h0,        0, 32'h8000_0008,0,32'h0));
        vecs.push_back(mk("stall_redir", 1,0,32'h0,        1,32'h8000_0100,0,32'h0,        32'h0,        0, 32'h8000_0100,0,32'h0));
        vecs.push_back(mk("trap_prio",   0,1,32'h8000_0200,1,32'h8000_0100,0,32'h0,        32'h0,        0, 32'h8000_0200,0,32'h0));
        vecs.push_back(mk("alloc",       0,0,32'h0,        1,32'h8000_0010,1,32'h8000_0010,32'h8000_0040,1, 32'h8000_0010,1,32'h8000_0040));
        vecs.push_back(mk("follow",      0,0,32'h0,        0,32'h0,        0,32'h0,        32'h0,        0, 32'h8000_0040,0,32'h0));
        vecs.push_back(mk("back",        0,0,32'h0,        1,32'h8000_0010,0,32'h0,        32'h0,        0, 32'h8000_0010,1,32'h8000_0040));
        vecs.push_back(mk("alias",       0,0,32'h0,        1,32'h8000_0030,0,32'h0,        32'h0,        0, 32'h8000_0030,0,32'h0));
        vecs.push_back(mk("back2",       0,0,32'h0,        1,32'h8000_0010,0,32'h0,        32'h0,        0, 32'h8000_0010,1,32'h8000_0040));
        vecs.push_back(mk("rbw_nt1",     0,0,32'h0,        0,32'h0,        1,32'h8000_0010,32'h0,        0, 32'h8000_0040,0,32'h0));
        vecs.push_back(mk("nt2",         0,0,32'h0,        1,32'h8000_0010,1,32'h8000_0010,32'h0,        0, 32'h8000_0010,0,32'h0));
        vecs.push_back(mk("seq_nt",      0,0,32'h0,        0,32'h0,        0,32'h0,        32'h0,        0, 32'h8000_0014,0,32'h0));
        vecs.push_back(mk("stall_tr1",   1,0,32'h0,        0,32'h0,        1,32'h8000_0010,32'h8000_0080,1, 32'h8000_0014,0,32'h0));
        vecs.push_back(mk("stall_tr2",   1,0,32'h0,        0,32'h0,        1,32'h8000_0010,32'h8000_0080,1, 32'h8000_0014,0,32'h0));
        vecs.push_back(mk("retrained",   0,0,32'h0,        1,32'h8000_0010,0,32'h0,        32'h0,        0, 32'h8000_0010,1,32'h8000_0080));
        vecs.push_back(mk("follow2",     0,0,32'h0,        0,32'h0,        0,32'h0,        32'h0,        0, 32'h8000_0080,0,32'h0));
        vecs.push_back(mk("wrap_set",    0,0,32'h0,        1,32'hFFFF_FFFC,0,32'h0,        32'h0,        0, 32'hFFFF_FFFC,0,32'h0));
        vecs.push_back(mk("wrap",        0,0,32'h0,        0,32'h0,        0,32'h0,        32'h0,        0, 32'h0000_0000,0,32'h0));

        // Boot: three cycles in reset
        reset_n = 1'b0;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            check_state($sformatf("reset%0d", i), 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1);
        end
        reset_n = 1'b1;

        // Table-driven main sequence: inputs for one edge, outputs after it
        for (int i = 0; i < vecs.size(); i++) begin
            stall           = vecs[i].stall;
            trap_valid      = vecs[i].trap_valid;
            trap_target     = vecs[i].trap_target;
            redirect_valid  = vecs[i].redirect_valid;
            redirect_target = vecs[i].redirect_target;
            upd_valid       = vecs[i].upd_valid;
            upd_pc          = vecs[i].upd_pc;
            upd_target      = vecs[i].upd_target;
            upd_taken       = vecs[i].upd_taken;
            step();
            check_state(vecs[i].name, vecs[i].exp_pc, 1'b1, vecs[i].exp_pred,
                        vecs[i].exp_ptgt, vecs[i].exp_pred);
        end
        idle_inputs();

        // Reset mid-run with a trained entry and competing requests
        redirect_valid = 1'b1; redirect_target = 32'h8000_0010;
        step();
        check_state("pre_reset", 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0080, 1'b1);

        reset_n = 1'b0;
        upd_valid = 1'b1; upd_pc = 32'h8000_0010; upd_target = 32'h8000_0040; upd_taken = 1'b1;
        trap_valid = 1'b1; trap_target = 32'h0000_0123;
        redirect_valid = 1'b1; redirect_target = 32'h8000_0100;
        step();
        check_state("mid_reset", 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1);

        idle_inputs();
        step();
        check_state("mid_reset2", 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1);

        reset_n = 1'b1;
        step();
        check_state("reboot", 32'h8000_0000, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        check_state("reboot_seq", 32'h8000_0004, 1'b1, 1'b0, 32'h0, 1'b0);

        redirect_valid = 1'b1; redirect_target = 32'h8000_0010;
        step();
        check_state("btb_cleared", 32'h8000_0010, 1'b1, 1'b0, 32'h0, 1'b0);
        idle_inputs();
        step();
        check_state("after_clear", 32'h8000_0014, 1'b1, 1'b0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
